// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU-side types for the memory port arbiter: FSM states, grant
// encoding and the default datapath width.
package mem_port_arbiter_pkg;

    // Datapath width used across the CPU (data and byte addresses).
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-port block RAM between the instruction-fetch miss port
// and the data-side miss/uncached port. One outstanding request per side,
// round-robin on ties, MEM_LAT-cycle access, then a one-cycle ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_WIDTH,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_web,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int CW = $clog2(MEM_LAT + 1);
    // Counter value of the final ISSUE cycle; the counter stops here.
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    arb_state_t        state_q, state_d;
    grant_t            gnt_q, gnt_d;
    grant_t            last_q, last_d;
    grant_t            pick;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              issue, resp;

    // Next-state logic: round-robin pick in IDLE, latency count in ISSUE,
    // single ack cycle in RESP.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        // Data wins when alone, or on a tie when fetch was granted last.
        if (d_req && (!i_req || last_q == GNT_I)) pick = GNT_D;
        else                                      pick = GNT_I;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    gnt_d  = pick;
                    last_d = pick;
                    if (pick == GNT_D) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end else begin
                        addr_d  = i_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == CNT_LAST) begin
                    // Read data is valid at the end of the last access cycle.
                    if (!we_q) rdata_d = mem_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset leaves fetch as last grant so data wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_I;
            last_q  <= GNT_I;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign issue = (state_q == ISSUE);
    assign resp  = (state_q == RESP);

    // Memory bus is quiet outside ISSUE; the write strobe fires once, on the
    // first access cycle only.
    assign mem_addr       = issue ? addr_q  : '0;
    assign mem_write_data = issue ? wdata_q : '0;
    assign mem_web        = issue && we_q && (cnt_q == '0);

    assign i_ack   = resp && (gnt_q == GNT_I);
    assign d_ack   = resp && (gnt_q == GNT_D);
    assign i_rdata = i_ack ? rdata_q : '0;
    assign d_rdata = d_ack ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LAT=1 (index 0) and one
// with MEM_LAT=3 (index 1), directed scenarios plus random single-side
// transactions checked against a transaction-level expectation.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, i_req, d_req, d_we, i_ack, d_ack, mem_web;
    logic [1:0][31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
    logic [1:0][31:0] mem_addr, mem_write_data, mem_data;

    int n_chk  = 0;
    int n_fail = 0;

    // Last value the arbiter returned for a read, per instance.
    logic [1:0][31:0] rmodel;
    logic             force_mem = 1'b0;
    logic [31:0]      force_val = '0;

    mem_port_arbiter #(.DATA_W(32), .MEM_LAT(1)) u_l1 (
        .clk(clk), .rst(rst[0]),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ack(i_ack[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_ack(d_ack[0]),
        .mem_addr(mem_addr[0]), .mem_write_data(mem_write_data[0]),
        .mem_web(mem_web[0]), .mem_data(mem_data[0])
    );

    mem_port_arbiter #(.DATA_W(32), .MEM_LAT(3)) u_l3 (
        .clk(clk), .rst(rst[1]),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ack(i_ack[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_ack(d_ack[1]),
        .mem_addr(mem_addr[1]), .mem_write_data(mem_write_data[1]),
        .mem_web(mem_web[1]), .mem_data(mem_data[1])
    );

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_mem(input int k, output logic [31:0] v);
        v = force_mem ? force_val : 32'($urandom);
        mem_data[k] = v;
    endtask

    // Everything quiet: no acks, no memory activity, zero read data.
    task automatic idle_chk(input int k, input string tag);
        chk({tag, "_ctl"},   {29'd0, i_ack[k], d_ack[k], mem_web[k]}, 32'd0);
        chk({tag, "_maddr"}, mem_addr[k], 32'd0);
        chk({tag, "_mwd"},   mem_write_data[k], 32'd0);
        chk({tag, "_rd"},    i_rdata[k] | d_rdata[k], 32'd0);
    endtask

    task automatic reset_dut(input int k);
        @(negedge clk);
        rst[k] = 1'b1; i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
        @(negedge clk);
        rst[k] = 1'b0;
        rmodel[k] = '0;
        idle_chk(k, "reset");
    endtask

    // One request from one side, presented in an IDLE cycle. With linger the
    // requester keeps req high for one cycle past the ack, which must cause a
    // second identical access.
    task automatic run_txn(input int k, input bit side_d, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit linger, input string tag);
        logic [31:0] v, last_v, exp_rd;
        @(negedge clk);
        idle_chk(k, {tag, "_pre"});
        if (side_d) begin
            d_addr[k] = addr; d_wdata[k] = wdata; d_we[k] = we; d_req[k] = 1'b1;
        end else begin
            i_addr[k] = addr; i_req[k] = 1'b1;
        end
        @(posedge clk);
        last_v = '0;
        for (int pass = 0; pass <= (linger ? 1 : 0); pass++) begin
            for (int c = 1; c <= lat(k); c++) begin
                @(negedge clk);
                chk({tag, "_maddr"}, mem_addr[k], addr);
                chk({tag, "_mwd"}, mem_write_data[k], side_d ? wdata : 32'd0);
                chk({tag, "_web"}, {31'd0, mem_web[k]}, {31'd0, (we && c == 1)});
                chk({tag, "_noack"}, {30'd0, i_ack[k], d_ack[k]}, 32'd0);
                if (pass == 1 && c == 1) begin
                    i_req[k] = 1'b0; d_req[k] = 1'b0;
                end
                drive_mem(k, v);
                last_v = v;
                @(posedge clk);
            end
            @(negedge clk);
            chk({tag, "_ack"}, {30'd0, i_ack[k], d_ack[k]}, side_d ? 32'd1 : 32'd2);
            exp_rd = we ? rmodel[k] : last_v;
            if (!we) rmodel[k] = last_v;
            chk({tag, "_rdata"}, side_d ? d_rdata[k] : i_rdata[k], exp_rd);
            chk({tag, "_rdoth"}, side_d ? i_rdata[k] : d_rdata[k], 32'd0);
            chk({tag, "_mquiet"}, {31'd0, mem_web[k]} | mem_addr[k], 32'd0);
            if (!(linger && pass == 0)) begin
                i_req[k] = 1'b0; d_req[k] = 1'b0;
            end
            @(posedge clk);
            if (linger && pass == 0) begin
                @(negedge clk);
                idle_chk(k, {tag, "_gap"});
                @(posedge clk);
            end
        end
    endtask

    // Both sides request continuously; each acked side drops req in the ack
    // cycle and re-raises it in the IDLE cycle, so every grant is a tie.
    task automatic tie_run(input int k, input int n, input string tag);
        int   got = 0, last_ack = -1, cyc = 0;
        bit   exp_d = 1'b1, raise_i = 1'b0, raise_d = 1'b0;
        logic [31:0] v;
        @(negedge clk);
        i_addr[k] = 32'h200; d_addr[k] = 32'h204; d_we[k] = 1'b0; d_wdata[k] = '0;
        i_req[k] = 1'b1; d_req[k] = 1'b1;
        while (got < n && cyc < 60) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            drive_mem(k, v);
            if (raise_i) i_req[k] = 1'b1;
            if (raise_d) d_req[k] = 1'b1;
            raise_i = 1'b0; raise_d = 1'b0;
            chk({tag, "_both"}, {31'd0, i_ack[k] & d_ack[k]}, 32'd0);
            if (i_ack[k] || d_ack[k]) begin
                chk({tag, "_order"}, {31'd0, d_ack[k]}, {31'd0, exp_d});
                exp_d = !exp_d;
                if (last_ack >= 0) chk({tag, "_space"}, 32'(cyc - last_ack), 32'(lat(k) + 2));
                last_ack = cyc;
                got++;
                if (got == n) begin
                    i_req[k] = 1'b0; d_req[k] = 1'b0;
                end else if (d_ack[k]) begin
                    d_req[k] = 1'b0; raise_d = 1'b1;
                end else begin
                    i_req[k] = 1'b0; raise_i = 1'b1;
                end
            end
        end
        chk({tag, "_count"}, 32'(got), 32'(n));
        i_req[k] = 1'b0; d_req[k] = 1'b0;
        repeat (lat(k) + 3) @(posedge clk);
    endtask

    // Write in flight, reset in its first ISSUE cycle: nothing may follow.
    task automatic reset_mid(input int k);
        @(negedge clk);
        d_addr[k] = 32'h300; d_wdata[k] = 32'hA5A5_5A5A; d_we[k] = 1'b1; d_req[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rmid_web1", {31'd0, mem_web[k]}, 32'd1);
        rst[k] = 1'b1; d_req[k] = 1'b0; d_we[k] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[k] = 1'b0;
        rmodel[k] = '0;
        idle_chk(k, "rmid_after");
        for (int c = 0; c < lat(k) + 2; c++) begin
            @(negedge clk);
            chk("rmid_quiet", {29'd0, i_ack[k], d_ack[k], mem_web[k]}, 32'd0);
        end
    endtask

    initial begin
        rst = 2'b11; i_req = '0; d_req = '0; d_we = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_data = '0; rmodel = '0;
        repeat (2) @(posedge clk);
        reset_dut(0);
        reset_dut(1);

        // Lone read, fixed memory value.
        force_mem = 1'b1; force_val = 32'hDEAD_BEEF;
        run_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, "lone_rd");
        force_mem = 1'b0;

        // Write right after reset: read data register still 0.
        reset_dut(0);
        run_txn(0, 1'b1, 1'b1, 32'h80, 32'h1234_5678, 1'b0, "wr");

        // Ties out of reset.
        reset_dut(0);
        tie_run(0, 4, "tie1");
        reset_dut(1);
        tie_run(1, 4, "tie3");

        // Long-latency fetch read with memory data changing every cycle.
        reset_dut(1);
        run_txn(1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, "lat3_rd");

        // Reset during a write, then the next tie must go to data.
        for (int k = 0; k < 2; k++) begin
            reset_dut(k);
            reset_mid(k);
            tie_run(k, 1, "rmid_tie");
        end

        // Lingering request repeats the access.
        reset_dut(0);
        run_txn(0, 1'b1, 1'b0, 32'h44, 32'h9, 1'b1, "linger");
        reset_dut(1);
        run_txn(1, 1'b1, 1'b1, 32'h48, 32'h77, 1'b1, "linger3");

        // Random single-side traffic on both instances.
        for (int t = 0; t < 60; t++) begin
            int  k;
            bit  sd, we, lg;
            k  = int'($urandom_range(0, 1));
            sd = 1'($urandom_range(0, 1));
            we = sd ? 1'($urandom_range(0, 1)) : 1'b0;
            lg = ($urandom_range(0, 7) == 0);
            run_txn(k, sd, we, {32'($urandom) & 32'hFFFF_FFFC}, 32'($urandom), lg, "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares the single-port data/instruction block RAM between the instruction-fetch miss port and the data-cache miss/uncached port of the pipelined CPU. It accepts one outstanding request from each requester and grants them round-robin. For the granted request it drives the memory address, write data and write enable for the configured read latency, captures the read data, and returns a one-cycle acknowledge. It sits between the two cache blocks and the memory/MMIO bus.

## Interface
Parameters:
- DATA_W, default 32: data and address width.
- MEM_LAT, default 1: memory read latency in cycles; must be ≥ 1.

Ports (all outputs are registered or decoded from registered state):
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- i_req  in  1  fetch-side request; held high until i_ack.
- i_addr  in  DATA_W  fetch byte address.
- i_rdata  out  DATA_W  read data; valid only while i_ack=1.
- i_ack  out  1  one-cycle completion pulse to the fetch side.
- d_req  in  1  data-side request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  DATA_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data; valid only while d_ack=1.
- d_ack  out  1  one-cycle completion pulse to the data side.
- mem_addr  out  DATA_W  memory address.
- mem_write_data  out  DATA_W  memory write data.
- mem_web  out  1  memory write enable, 1 = write.
- mem_data  in  DATA_W  memory read data.

## Operation
FSM states:
- IDLE: if any request is pending, pick a grant, latch addr/wdata/we (fetch-side we=0), clear the latency counter and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive mem_addr = latched addr and mem_write_data = latched wdata for exactly MEM_LAT cycles.
  - mem_web = latched we in the first ISSUE cycle only, so a write produces exactly one pulse.
  - On the last ISSUE cycle, if the access is a read, capture mem_data into rdata_q. For a write, rdata_q is not updated.
  - Then go to RESP.
- RESP: assert the ack of the granted side for one cycle. The granted side's rdata = rdata_q; the other side's rdata = 0. Go to IDLE. Requests are not sampled in RESP.

Arbitration and output rules:
- Arbitration: if only one request is pending, grant it. If both are pending, grant the side not granted last; last_grant updates at grant time.
- Outside ISSUE: mem_addr = 0, mem_write_data = 0, mem_web = 0. Both acks are 0 outside RESP.
- Requesters must deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.

## Timing
Reset values and reset behaviour:
- After rst: state = IDLE, last_grant = fetch (so data wins the first tie), rdata_q = 0, counter = 0.
- All outputs are 0 after rst.
- rst mid-transaction aborts it: no ack and no further mem_web pulse. The requester re-issues.

Latency and throughput:
- Request sampled in IDLE at cycle T: ISSUE occupies T+1 … T+MEM_LAT, and ack is high at T+MEM_LAT+1.
- MEM_LAT=1 gives ack 2 cycles after sampling.
- Back-to-back service: the next grant is sampled at T+MEM_LAT+2, so one transaction takes MEM_LAT+2 cycles.
- With both sides requesting continuously, grants alternate D, I, D, I…
- The counter width is $clog2(MEM_LAT+1). The counter saturates at MEM_LAT−1 and never wraps.

## Structure
- Shared package (CPU package): typedef enum arb_state_t {IDLE, ISSUE, RESP} and typedef enum grant_t {GNT_I, GNT_D}.
- Widths use the existing DATA_WIDTH constant from Constants.vh.
- Single module with no sub-module; the 2-way round-robin pick is a few lines inline.

## Test plan
- Lone read (MEM_LAT=1): d_req=1, d_we=0, d_addr=0x0000_0040, memory returns 0xDEAD_BEEF.
  - Required: mem_addr=0x40 for one cycle, d_ack two cycles after sampling with d_rdata=0xDEAD_BEEF, i_ack stays 0.
- Write: d_we=1, d_addr=0x80, d_wdata=0x1234_5678.
  - Required: exactly one mem_web pulse with mem_addr=0x80 and mem_write_data=0x1234_5678, then d_ack, and d_rdata=0.
- Simultaneous requests: i_req and d_req both high out of reset and held.
  - Required: grant order D, I, D, I. Each ack is spaced 3 cycles apart (MEM_LAT=1). No ack is ever asserted on both sides at once.
- MEM_LAT=3 read: i_addr=0x100.
  - Required: mem_addr held at 0x100 for 3 cycles, mem_web=0 throughout, i_ack at T+4, and i_rdata equals mem_data sampled in the third ISSUE cycle.
- Reset mid-ISSUE during a write: assert rst in the ISSUE cycle.
  - Required: the next cycle is IDLE with all outputs 0, no ack, and no second mem_web pulse. The following data/fetch tie goes to D.
- Lingering request: hold d_req one extra cycle after d_ack.
  - Required: a second full transaction to the same address is issued.
